id_ex_hazard_stage: RTL
=======================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, directly downstream of the control unit.
- Latches the decoder's control bundle (Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite) together with the ID-stage operands.
- Contains load-use hazard detection. It stalls PC and IF/ID, and inserts a zero-control bubble into EX.
- Branch flush squashes the ID instruction. Saturating stall and flush event counters are provided for debug.

Parameters:
XLEN, 32, datapath width of register data, immediate and PC
CNT_W, 16, width of each event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_opcode  in  7  instruction[6:0] of the ID instruction
id_rs1  in  5  instruction[19:15]
id_rs2  in  5  instruction[24:20]
id_rd  in  5  instruction[11:7]
id_funct  in  4  {instruction[30], instruction[14:12]}
id_pc  in  XLEN  PC of the ID instruction
id_rdata1  in  XLEN  register file read port 1
id_rdata2  in  XLEN  register file read port 2
id_imm  in  XLEN  sign-extended immediate
id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  control unit outputs
id_alu_op  in  2  control unit ALUOp
flush_i  in  1  branch taken in EX; squash the ID instruction
cnt_clr_i  in  1  synchronous clear of both counters
stall_o  out  1  hold PC and IF/ID this cycle
ex_* (one per id_* input above)  out  same widths  registered copies
ex_valid  out  1  EX slot holds a real instruction
stall_cnt  out  CNT_W  cycles with stall_o=1
flush_cnt  out  CNT_W  cycles with flush_i=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All ex_* outputs, ex_valid, stall_cnt and flush_cnt go to 0 immediately.
  - stall_o is 0 while in reset.
- Operand-use decode (combinational, from id_opcode):
  - uses_rs1 = 0 for LUI 0110111, AUIPC 0010111 and JAL 1101111; 1 otherwise.
  - uses_rs2 = 1 only for R 0110011, S 0100011 and B 1100011.
- hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- stall_o = hazard & ~flush_i. It is combinational with zero latency. Flush has priority because a wrong-path instruction never stalls.
- Each rising edge, priority flush > stall > normal:
  - flush_i=1 or stall_o=1 (bubble):
    - All ex_ control bits and ex_alu_op load 0; ex_valid loads 0.
    - Data and address fields (pc, rdata, imm, rs, rd, funct) load the id_ values anyway; they are don't-care downstream.
  - Otherwise: every ex_ field loads its id_ value and ex_valid loads 1.
- Load-use stall is exactly one cycle:
  - The bubble clears ex_valid, so hazard drops the next cycle.
  - ID then re-presents the same instruction and it advances.
- Back-to-back loads with a dependency each stall once. No stall when ex_rd==0.
- Counters:
  - stall_cnt increments on every edge where stall_o=1; flush_cnt increments on every edge where flush_i=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr_i=1 loads 0 and takes priority over a same-cycle increment.
- Reset asserted mid-stall: outputs clear at once. After release the first edge loads normally, since ex_valid=0 means no hazard.
- Design is fully synchronous apart from the reset. There are no combinational paths from id_ data fields to ex_ outputs.

Test Plan:
1. Reset, then release. Present lw x5,0(x1) (opcode 0000011, rd=5, mem_read=1), then add x6,x5,x7 (rs1=5).
   -> Cycle 2: stall_o=1. Next edge: ex_valid=0 and all ex controls are 0. Following edge: ex_rd=6, ex_reg_write=1, ex_alu_op=10. stall_cnt=1.
2. lw x0,0(x1), then add x6,x0,x0.
   -> stall_o stays 0 and the instructions flow back-to-back with ex_valid=1.
3. lw x5, then addi x6,x1,5 (opcode 0010011, rs1=1, instr[24:20]=5).
   -> stall_o=0 because uses_rs2=0. lw x5 then sw x5,0(x2) (rs2=5) -> stall_o=1.
4. Load-use hazard with flush_i=1 in the same cycle.
   -> stall_o=0. Next edge: ex_valid=0, controls 0. flush_cnt=1, stall_cnt unchanged.
5. CNT_W=4: hold flush_i=1 for 20 cycles.
   -> flush_cnt reaches 15 and stays there. Assert cnt_clr_i together with flush_i -> flush_cnt=0.
6. Drive rst_n low between clock edges while ex_valid=1 and counters are nonzero.
   -> All outputs are 0 before the next edge. After release a plain R-type loads normally with ex_valid=1.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush bubbling
// and saturating stall/flush event counters for debug.
module id_ex_hazard_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [1:0]       id_alu_op,

  input  logic             flush_i,
  input  logic             cnt_clr_i,

  output logic             stall_o,

  output logic [6:0]       ex_opcode,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rdata1,
  output logic [XLEN-1:0]  ex_rdata2,
  output logic [XLEN-1:0]  ex_imm,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic [1:0]       ex_alu_op,
  output logic             ex_valid,

  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic uses_rs1;
  logic uses_rs2;
  logic rs1_match;
  logic rs2_match;
  logic hazard;
  logic bubble;

  // Which source registers the ID instruction actually reads.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
      default:                  uses_rs1 = 1'b1;
    endcase
    case (id_opcode)
      OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                   uses_rs2 = 1'b0;
    endcase
  end

  assign rs1_match = uses_rs1 && (ex_rd == id_rs1);
  assign rs2_match = uses_rs2 && (ex_rd == id_rs2);
  assign hazard    = ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_match || rs2_match);

  // Stall contract: while stall_o=1 the upstream PC and IF/ID hold, so the
  // same ID instruction is presented again next cycle; flush always wins
  // because a wrong-path instruction must never hold the front end.
  assign stall_o = hazard && !flush_i;
  assign bubble  = flush_i || stall_o;

  // Data and address fields load unconditionally; only control is bubbled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_opcode <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct  <= '0;
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
    end else begin
      ex_opcode <= id_opcode;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct  <= id_funct;
      ex_pc     <= id_pc;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_valid      <= 1'b0;
    end else if (bubble) begin
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_valid      <= 1'b0;
    end else begin
      ex_branch     <= id_branch;
      ex_mem_read   <= id_mem_read;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_mem_write  <= id_mem_write;
      ex_alu_src    <= id_alu_src;
      ex_reg_write  <= id_reg_write;
      ex_alu_op     <= id_alu_op;
      ex_valid      <= 1'b1;
    end
  end

  // Saturating event counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_i && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
